// File: rtl/semaforo_pkg.sv
// Shared types and constants for the pedestrian crossing controller.
package semaforo_pkg;

  localparam int unsigned BCD_W = 4;

  // {red, yellow, green} combination that counts as a safe vehicle red
  localparam logic [2:0] LAMP_SAFE_RED = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_t;

  // Elaboration-time conversion of a parameter (0..99) into a BCD pair
  function automatic bcd_t to_bcd(input int unsigned v);
    bcd_t r;
    r.tens = BCD_W'((v / 10) % 10);
    r.ones = BCD_W'(v % 10);
    return r;
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t v);
    bcd_t r;
    r = v;
    if (v.ones == '0) begin
      r.ones = BCD_W'(9);
      r.tens = v.tens - BCD_W'(1);
    end else begin
      r.ones = v.ones - BCD_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/ped_debounce.sv
// Button synchronizer and debouncer; emits a one-cycle pulse per accepted press.
module ped_debounce #(
  parameter int unsigned DEBOUNCE = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // A level change is accepted after DEBOUNCE consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        cnt    <= '0;
        stable <= sync2;
        press  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/semaforo_peatonal.sv
// Pedestrian WALK / DON'T WALK controller slaved to the vehicle light's red phase.
module semaforo_peatonal
  import semaforo_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned DEBOUNCE = 1000000,
  parameter int unsigned WALK_S   = 20,
  parameter int unsigned FLASH_S  = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             red_i,
  input  logic             yellow_i,
  input  logic             green_i,
  input  logic             btn_i,
  output logic             walk_o,
  output logic             dont_walk_o,
  output logic             req_pending_o,
  output logic [BCD_W-1:0] cnt_tens_o,
  output logic [BCD_W-1:0] cnt_ones_o,
  output logic             cnt_valid_o
);

  localparam int unsigned PW        = $clog2(TICK_DIV);
  localparam bcd_t        WALK_BCD  = to_bcd(WALK_S);
  localparam bcd_t        FLASH_BCD = to_bcd(FLASH_S);
  localparam bcd_t        ONE_BCD   = to_bcd(1);

  logic          press;
  logic          safe_red_q;
  logic          safe_red_d;
  logic          red_start;
  logic [PW-1:0] presc;
  logic          tick;
  logic          half;
  state_t        state;
  bcd_t          secs;
  bcd_t          secs_dec;

  ped_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk   (clk_i),
    .rst   (rst_i),
    .btn   (btn_i),
    .press (press)
  );

  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign half     = (presc == PW'(TICK_DIV / 2 - 1));
  assign secs_dec = bcd_dec(secs);

  // Registered safe-red qualification and its registered rising edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      safe_red_q <= 1'b0;
      safe_red_d <= 1'b0;
      red_start  <= 1'b0;
    end else begin
      safe_red_q <= ({red_i, yellow_i, green_i} == LAMP_SAFE_RED);
      safe_red_d <= safe_red_q;
      red_start  <= safe_red_q & ~safe_red_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      presc         <= '0;
      secs          <= '0;
      walk_o        <= 1'b0;
      dont_walk_o   <= 1'b1;
      req_pending_o <= 1'b0;
      cnt_tens_o    <= '0;
      cnt_ones_o    <= '0;
      cnt_valid_o   <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (press) req_pending_o <= 1'b1;
      case (state)
        IDLE: begin
          walk_o      <= 1'b0;
          dont_walk_o <= 1'b1;
          cnt_valid_o <= 1'b0;
          cnt_tens_o  <= '0;
          cnt_ones_o  <= '0;
          // A request is served only if it was latched before this red began
          if (red_start && req_pending_o) begin
            state       <= WALK;
            secs        <= WALK_BCD;
            presc       <= '0;
            walk_o      <= 1'b1;
            dont_walk_o <= 1'b0;
            if (!press) req_pending_o <= 1'b0;
          end
        end
        WALK: begin
          if (!safe_red_q) begin
            state       <= IDLE;
            walk_o      <= 1'b0;
            dont_walk_o <= 1'b1;
          end else if (tick) begin
            if (secs == ONE_BCD) begin
              state       <= CLEAR;
              secs        <= FLASH_BCD;
              walk_o      <= 1'b0;
              dont_walk_o <= 1'b1;
              cnt_valid_o <= 1'b1;
              cnt_tens_o  <= FLASH_BCD.tens;
              cnt_ones_o  <= FLASH_BCD.ones;
            end else begin
              secs <= secs_dec;
            end
          end
        end
        CLEAR: begin
          if (!safe_red_q || (tick && secs == ONE_BCD)) begin
            state       <= IDLE;
            walk_o      <= 1'b0;
            dont_walk_o <= 1'b1;
            cnt_valid_o <= 1'b0;
            cnt_tens_o  <= '0;
            cnt_ones_o  <= '0;
          end else begin
            if (tick || half) dont_walk_o <= ~dont_walk_o;
            if (tick) begin
              secs       <= secs_dec;
              cnt_tens_o <= secs_dec.tens;
              cnt_ones_o <= secs_dec.ones;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_semaforo_peatonal.sv
// Directed bench for semaforo_peatonal: cycle table plus multi-cycle corner sequences.
module tb_semaforo_peatonal;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       red = 1'b0;
  logic       yellow = 1'b0;
  logic       green = 1'b0;
  logic       btn = 1'b0;
  logic       walk;
  logic       dont_walk;
  logic       req_pending;
  logic [3:0] cnt_tens;
  logic [3:0] cnt_ones;
  logic       cnt_valid;
  logic [11:0] outv;

  int tests = 0;
  int failed = 0;

  // Flag nibble is {walk, dont_walk, req_pending, cnt_valid}
  localparam logic [3:0] F_IDLE    = 4'b0100;
  localparam logic [3:0] F_IDLE_RQ = 4'b0110;
  localparam logic [3:0] F_WALK    = 4'b1000;
  localparam logic [3:0] F_CLR_ON  = 4'b0101;
  localparam logic [3:0] F_CLR_OFF = 4'b0001;

  typedef struct {
    int          n;
    logic [4:0]  in;   // {rst, red, yellow, green, btn}
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  semaforo_peatonal #(
    .TICK_DIV (4),
    .DEBOUNCE (3),
    .WALK_S   (3),
    .FLASH_S  (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .red_i         (red),
    .yellow_i      (yellow),
    .green_i       (green),
    .btn_i         (btn),
    .walk_o        (walk),
    .dont_walk_o   (dont_walk),
    .req_pending_o (req_pending),
    .cnt_tens_o    (cnt_tens),
    .cnt_ones_o    (cnt_ones),
    .cnt_valid_o   (cnt_valid)
  );

  always #5 clk = ~clk;

  assign outv = {walk, dont_walk, req_pending, cnt_valid, cnt_tens, cnt_ones};

  function automatic logic [11:0] e(input logic [3:0] f, input logic [3:0] t, input logic [3:0] o);
    return {f, t, o};
  endfunction

  task automatic add(input int n, input logic [4:0] in, input logic [11:0] exp);
    vec_t v;
    v.n = n;
    v.in = in;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic press_btn();
    btn = 1'b1;
    repeat (8) cyc();
    btn = 1'b0;
    repeat (6) cyc();
  endtask

  initial begin
    int rises;
    int rise_at;
    logic prev;

    // Reset, request latch, full service, then a red with no request
    add(2,  5'b10000, e(F_IDLE,    4'd0, 4'd0));
    add(5,  5'b00001, e(F_IDLE,    4'd0, 4'd0));
    add(3,  5'b00001, e(F_IDLE_RQ, 4'd0, 4'd0));
    add(6,  5'b00000, e(F_IDLE_RQ, 4'd0, 4'd0));
    add(2,  5'b01000, e(F_IDLE_RQ, 4'd0, 4'd0));
    add(12, 5'b01000, e(F_WALK,    4'd0, 4'd0));
    add(2,  5'b01000, e(F_CLR_ON,  4'd0, 4'd2));
    add(2,  5'b01000, e(F_CLR_OFF, 4'd0, 4'd2));
    add(2,  5'b01000, e(F_CLR_ON,  4'd0, 4'd1));
    add(2,  5'b01000, e(F_CLR_OFF, 4'd0, 4'd1));
    add(4,  5'b01000, e(F_IDLE,    4'd0, 4'd0));
    add(3,  5'b00000, e(F_IDLE,    4'd0, 4'd0));
    add(20, 5'b01000, e(F_IDLE,    4'd0, 4'd0));
    add(3,  5'b00000, e(F_IDLE,    4'd0, 4'd0));

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        {rst, red, yellow, green, btn} = tbl[i].in;
        cyc();
        chk($sformatf("table[%0d].%0d", i, k), outv, tbl[i].exp);
      end
    end

    // Bouncy button: 1,0,1 then held; exactly one request rise
    rises = 0;
    rise_at = -1;
    prev = req_pending;
    for (int k = 0; k < 14; k++) begin
      btn = (k == 1) ? 1'b0 : 1'b1;
      cyc();
      if (req_pending && !prev) begin
        rises++;
        rise_at = k;
      end
      prev = req_pending;
    end
    btn = 1'b0;
    chk("bounce_rises", 12'(rises), 12'd1);
    chk("bounce_rise_cycle", 12'(rise_at), 12'd7);
    repeat (8) cyc();

    // Reset asserted mid-WALK
    red = 1'b1;
    repeat (5) cyc();
    chk("pre_reset_walk", 12'(walk), 12'd1);
    rst = 1'b1;
    cyc();
    chk("reset_mid_walk_1", outv, e(F_IDLE, 4'd0, 4'd0));
    cyc();
    chk("reset_mid_walk_2", outv, e(F_IDLE, 4'd0, 4'd0));
    rst = 1'b0;
    red = 1'b0;
    repeat (4) cyc();

    // Abort: red drops during WALK
    press_btn();
    chk("abort_req", 12'(req_pending), 12'd1);
    red = 1'b1;
    repeat (6) cyc();
    chk("abort_in_walk", 12'(walk), 12'd1);
    red = 1'b0;
    cyc();
    chk("abort_reg_delay", 12'(walk), 12'd1);
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk($sformatf("abort_idle.%0d", k), outv, e(F_IDLE, 4'd0, 4'd0));
    end

    // Lamp fault: red with green lit never qualifies
    press_btn();
    red = 1'b1;
    green = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk($sformatf("fault.%0d", k), {10'd0, walk, req_pending}, 12'b01);
    end
    green = 1'b0;
    cyc();
    cyc();
    chk("fault_clear_lat2", 12'(walk), 12'd0);
    cyc();
    chk("fault_clear_lat3", outv, e(F_WALK, 4'd0, 4'd0));
    repeat (11) cyc();
    // Press during CLEAR waits for the next red
    btn = 1'b1;
    cyc();
    chk("late_clear_entry", outv, e(F_CLR_ON, 4'd0, 4'd2));
    repeat (6) cyc();
    chk("late_press_latched", {10'd0, req_pending, cnt_valid}, 12'b11);
    btn = 1'b0;
    repeat (6) cyc();
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk($sformatf("late_wait.%0d", k), outv, e(F_IDLE_RQ, 4'd0, 4'd0));
    end
    red = 1'b0;
    repeat (3) cyc();
    red = 1'b1;
    cyc();
    cyc();
    chk("late_serve_lat2", 12'(walk), 12'd0);
    cyc();
    chk("late_serve_lat3", outv, e(F_WALK, 4'd0, 4'd0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
